// File: rtl/dcache_pkg.sv
// Shared types and address/tag field constants for the 2-way, 16-set write-back dcache controller.
package dcache_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned INDEX_W  = 4;
  localparam int unsigned OFFSET_W = 5;
  localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned LINE_W   = 256;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned WSEL_W   = 3;
  localparam int unsigned STAG_W   = TAG_W + 2;

  // SRAM tag word layout: {valid, dirty, tag}
  localparam int unsigned VALID_BIT = 24;
  localparam int unsigned DIRTY_BIT = 23;

  // CPU byte address fields: [31:9] tag, [8:5] index, [4:2] word
  localparam int unsigned TAG_LSB   = 9;
  localparam int unsigned INDEX_LSB = 5;
  localparam int unsigned WORD_LSB  = 2;

  typedef enum logic [1:0] {IDLE, WB, REFILL, FILL} state_t;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [INDEX_W-1:0] index);
    return {tag, index, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_word_merge.sv
// Combinational word select for loads and word replace for stores within a cache line.
module dcache_word_merge
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [WSEL_W-1:0] sel,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic [LINE_W-1:0] merged
);

  always_comb begin
    rdata  = line[sel*WORD_W +: WORD_W];
    merged = line;
    merged[sel*WORD_W +: WORD_W] = wdata;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate dcache miss/hit sequencer. Define DCACHE_STATS_EN to add
// hit/miss/write-back event counters (hit_cnt_o, miss_cnt_o, wb_cnt_o).
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cpu_req_i,
  input  logic                cpu_we_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [WORD_W-1:0]   cpu_data_i,
  output logic [WORD_W-1:0]   cpu_data_o,
  output logic                cpu_stall_o,
  output logic [INDEX_W-1:0]  sram_addr_o,
  output logic [STAG_W-1:0]   sram_tag_o,
  output logic [LINE_W-1:0]   sram_data_o,
  output logic                sram_enable_o,
  output logic                sram_write_o,
  input  logic [STAG_W-1:0]   sram_tag_i,
  input  logic [LINE_W-1:0]   sram_data_i,
  input  logic                sram_hit_i,
  output logic                mem_enable_o,
  output logic                mem_write_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [LINE_W-1:0]   mem_data_o,
  input  logic [LINE_W-1:0]   mem_data_i,
  input  logic                mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]         hit_cnt_o,
  output logic [31:0]         miss_cnt_o,
  output logic [31:0]         wb_cnt_o
`endif
);

  state_t              state;
  logic [TAG_W-1:0]    miss_tag;
  logic [INDEX_W-1:0]  miss_index;
  logic [LINE_W-1:0]   line_q;
  logic [TAG_W-1:0]    cpu_tag;
  logic [INDEX_W-1:0]  cpu_index;
  logic [WORD_W-1:0]   rd_word;
  logic [LINE_W-1:0]   merged_line;
  logic                idle;
  logic                hit_now;
  logic                miss_now;
  logic                victim_dirty;

  assign cpu_tag      = cpu_addr_i[TAG_LSB +: TAG_W];
  assign cpu_index    = cpu_addr_i[INDEX_LSB +: INDEX_W];
  assign idle         = (state == IDLE);
  assign hit_now      = idle & cpu_req_i & sram_hit_i;
  assign miss_now     = idle & cpu_req_i & ~sram_hit_i;
  assign victim_dirty = sram_tag_i[VALID_BIT] & sram_tag_i[DIRTY_BIT];

  dcache_word_merge u_merge (
    .line   (sram_data_i),
    .sel    (cpu_addr_i[WORD_LSB +: WSEL_W]),
    .wdata  (cpu_data_i),
    .rdata  (rd_word),
    .merged (merged_line)
  );

  // line_q holds the victim line through WB, then is overwritten by the refill line
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      line_q       <= '0;
      miss_tag     <= '0;
      miss_index   <= '0;
    end else begin
      case (state)
        IDLE: if (miss_now) begin
          line_q       <= sram_data_i;
          miss_tag     <= cpu_tag;
          miss_index   <= cpu_index;
          mem_enable_o <= 1'b1;
          if (victim_dirty) begin
            state       <= WB;
            mem_write_o <= 1'b1;
            mem_addr_o  <= line_addr(sram_tag_i[TAG_W-1:0], cpu_index);
          end else begin
            state       <= REFILL;
            mem_write_o <= 1'b0;
            mem_addr_o  <= line_addr(cpu_tag, cpu_index);
          end
        end
        WB: if (mem_ack_i) begin
          state       <= REFILL;
          mem_write_o <= 1'b0;
          mem_addr_o  <= line_addr(miss_tag, miss_index);
        end
        REFILL: if (mem_ack_i) begin
          state        <= FILL;
          line_q       <= mem_data_i;
          mem_enable_o <= 1'b0;
        end
        FILL: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_data_o    = line_q;
  assign cpu_stall_o   = cpu_req_i & ~(idle & sram_hit_i);
  assign cpu_data_o    = cpu_req_i ? rd_word : '0;
  assign sram_addr_o   = cpu_index;
  assign sram_enable_o = cpu_req_i | ~idle;

  always_comb begin
    sram_write_o = 1'b0;
    sram_tag_o   = {1'b1, 1'b0, cpu_tag};
    sram_data_o  = merged_line;
    if (state == FILL) begin
      sram_write_o = 1'b1;
      sram_tag_o   = {1'b1, 1'b0, miss_tag};
      sram_data_o  = line_q;
    end else if (hit_now & cpu_we_i) begin
      sram_write_o = 1'b1;
      sram_tag_o   = {1'b1, 1'b1, cpu_tag};
    end
    if (rst_i) sram_write_o = 1'b0;
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      wb_cnt_o   <= '0;
    end else begin
      if (hit_now) hit_cnt_o <= hit_cnt_o + 32'd1;
      if (miss_now) miss_cnt_o <= miss_cnt_o + 32'd1;
      if (miss_now & victim_dirty) wb_cnt_o <= wb_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a behavioural 2-way LRU SRAM and a fixed-latency memory.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i, cpu_we_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o, sram_tag_i;
  logic [255:0] sram_data_o, sram_data_i;
  logic         sram_enable_o, sram_write_o, sram_hit_i;
  logic         mem_enable_o, mem_write_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt_o, miss_cnt_o, wb_cnt_o;
`endif

  int vectors = 0;
  int errs = 0;

  always #5 clk_i = ~clk_i;

  dcache_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
    .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
`ifdef DCACHE_STATS_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .wb_cnt_o(wb_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    l = '0;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'hA000_0000 | {a[31:5], 5'b0} | 32'(i * 4);
    return l;
  endfunction

  // SRAM model: 2 ways x 16 sets, lru[set] names the way to evict next
  logic         model_clr;
  logic         sv [2][16];
  logic         sd [2][16];
  logic [22:0]  stg [2][16];
  logic [255:0] sdat [2][16];
  logic         lru [16];
  logic         h0, h1, sway;

  always @* begin
    h0 = sv[0][sram_addr_o] && (stg[0][sram_addr_o] == sram_tag_o[22:0]);
    h1 = sv[1][sram_addr_o] && (stg[1][sram_addr_o] == sram_tag_o[22:0]);
    sram_hit_i  = h0 | h1;
    sway        = h1 ? 1'b1 : (h0 ? 1'b0 : lru[sram_addr_o]);
    sram_tag_i  = {sv[sway][sram_addr_o], sd[sway][sram_addr_o], stg[sway][sram_addr_o]};
    sram_data_i = sdat[sway][sram_addr_o];
  end

  always @(posedge clk_i) begin
    if (model_clr) begin
      for (int s = 0; s < 16; s++) begin
        lru[s] <= 1'b0;
        for (int w = 0; w < 2; w++) begin
          sv[w][s] <= 1'b0; sd[w][s] <= 1'b0; stg[w][s] <= '0; sdat[w][s] <= '0;
        end
      end
    end else if (sram_enable_o) begin
      if (sram_write_o) begin
        sv[sway][sram_addr_o]   <= sram_tag_o[24];
        sd[sway][sram_addr_o]   <= sram_tag_o[23];
        stg[sway][sram_addr_o]  <= sram_tag_o[22:0];
        sdat[sway][sram_addr_o] <= sram_data_o;
        lru[sram_addr_o]        <= ~sway;
      end else if (sram_hit_i) begin
        lru[sram_addr_o] <= ~sway;
      end
    end
  end

  // Memory model: ack after mem_lat cycles of held request; logs transfers
  int           mem_lat;
  int           mcnt, rd_n, wb_n;
  logic [31:0]  last_rd, last_wb;
  logic [255:0] last_wb_data;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_ack_i <= 1'b0;
      mcnt      <= 0;
      if (model_clr) begin
        rd_n <= 0; wb_n <= 0; last_rd <= '0; last_wb <= '0; last_wb_data <= '0; mem_data_i <= '0;
      end
    end else begin
      mem_ack_i <= 1'b0;
      if (mem_enable_o && !mem_ack_i) begin
        if (mcnt == mem_lat - 1) begin
          mem_ack_i <= 1'b1;
          mcnt      <= 0;
          if (mem_write_o) begin
            wb_n <= wb_n + 1; last_wb <= mem_addr_o; last_wb_data <= mem_data_o;
          end else begin
            rd_n <= rd_n + 1; last_rd <= mem_addr_o; mem_data_i <= mem_line(mem_addr_o);
          end
        end else begin
          mcnt <= mcnt + 1;
        end
      end else begin
        mcnt <= 0;
      end
    end
  end

  // Memory request must hold address/data steady until its ack
  logic         p_en = 1'b0, p_ack = 1'b0;
  logic [31:0]  p_addr;
  logic [255:0] p_data;
  always @(negedge clk_i) begin
    if (!rst_i && mem_enable_o && p_en && !p_ack) begin
      chk("mem_addr_stable", mem_addr_o, p_addr);
      if (mem_write_o) chk("mem_data_stable", mem_data_o, p_data);
    end
    p_en   = mem_enable_o && !rst_i;
    p_ack  = mem_ack_i;
    p_addr = mem_addr_o;
    p_data = mem_data_o;
  end

  task automatic access(input logic [31:0] a, input logic we, input logic [31:0] d, output int n);
    @(posedge clk_i); #1;
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_data_i = d;
    n = 0;
    @(negedge clk_i);
    while (cpu_stall_o && n < 300) begin
      n++;
      @(negedge clk_i);
    end
    if (n >= 300) chk("stall_timeout", cpu_stall_o, 1'b0);
  endtask

  task automatic release_req();
    @(posedge clk_i); #1;
    cpu_req_i = 1'b0; cpu_we_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [255:0] exp_line;
    rst_i = 1'b1; model_clr = 1'b1; mem_lat = 1;
    cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_mem_enable", mem_enable_o, 1'b0);
    chk("rst_stall", cpu_stall_o, 1'b0);
    chk("rst_cpu_data", cpu_data_o, 32'h0);
    chk("rst_sram_write", sram_write_o, 1'b0);
    chk("rst_sram_enable", sram_enable_o, 1'b0);
    model_clr = 1'b0;
    @(posedge clk_i); #1; rst_i = 1'b0;

    // Cold load: clean miss, one refill of line 0x400
    access(32'h0000_0404, 1'b0, 32'h0, n);
    chk("cold_stall_cycles", 32'(n), 32'd4);
    chk("cold_rd_count", 32'(rd_n), 32'd1);
    chk("cold_wb_count", 32'(wb_n), 32'd0);
    chk("cold_refill_addr", last_rd, 32'h0000_0400);
    chk("cold_load_data", cpu_data_o, 32'hA000_0404);
    release_req();

    // Store hit: no stall, dirty tag written
    access(32'h0000_0404, 1'b1, 32'hDEAD_BEEF, n);
    chk("store_stall_cycles", 32'(n), 32'd0);
    chk("store_sram_write", sram_write_o, 1'b1);
    chk("store_sram_tag", sram_tag_o, 25'h180_0002);
    chk("store_sram_word", sram_data_o[63:32], 32'hDEAD_BEEF);
    chk("store_sram_word0", sram_data_o[31:0], 32'hA000_0400);
    release_req();

    access(32'h0000_0404, 1'b0, 32'h0, n);
    chk("reload_stall_cycles", 32'(n), 32'd0);
    chk("reload_data", cpu_data_o, 32'hDEAD_BEEF);
    release_req();

    // Same set, other way, slow memory
    mem_lat = 20;
    access(32'h0000_2404, 1'b0, 32'h0, n);
    chk("slow_stall_cycles", 32'(n), 32'd23);
    chk("slow_refill_addr", last_rd, 32'h0000_2400);
    chk("slow_wb_count", 32'(wb_n), 32'd0);
    chk("slow_load_data", cpu_data_o, 32'hA000_2404);
    release_req();

    // Third tag in set 0 evicts the dirty LRU line 0x400
    mem_lat = 1;
    access(32'h0000_4404, 1'b0, 32'h0, n);
    exp_line = mem_line(32'h0000_0400);
    exp_line[63:32] = 32'hDEAD_BEEF;
    chk("dirty_stall_cycles", 32'(n), 32'd6);
    chk("dirty_wb_count", 32'(wb_n), 32'd1);
    chk("dirty_wb_addr", last_wb, 32'h0000_0400);
    chk("dirty_wb_data", last_wb_data, exp_line);
    chk("dirty_refill_addr", last_rd, 32'h0000_4400);
    chk("dirty_load_data", cpu_data_o, 32'hA000_4404);
    release_req();

`ifdef DCACHE_STATS_EN
    chk("stats_hit", hit_cnt_o, 32'd5);
    chk("stats_miss", miss_cnt_o, 32'd3);
    chk("stats_wb", wb_cnt_o, 32'd1);
`endif

    // Reset in the middle of a refill abandons it
    mem_lat = 20;
    @(posedge clk_i); #1;
    cpu_req_i = 1'b1; cpu_addr_i = 32'h0000_6404;
    repeat (4) @(negedge clk_i);
    chk("mid_refill_enable", mem_enable_o, 1'b1);
    chk("mid_refill_write", mem_write_o, 1'b0);
    chk("mid_refill_addr", mem_addr_o, 32'h0000_6400);
    #2;
    rst_i = 1'b1; cpu_req_i = 1'b0;
    #1;
    chk("midrst_mem_enable", mem_enable_o, 1'b0);
    chk("midrst_stall", cpu_stall_o, 1'b0);
    chk("midrst_cpu_data", cpu_data_o, 32'h0);
    chk("midrst_sram_write", sram_write_o, 1'b0);
`ifdef DCACHE_STATS_EN
    chk("midrst_stats_hit", hit_cnt_o, 32'd0);
`endif
    @(posedge clk_i); #1; rst_i = 1'b0;
    mem_lat = 1;
    access(32'h0000_6404, 1'b0, 32'h0, n);
    chk("postrst_stall_cycles", 32'(n), 32'd4);
    chk("postrst_rd_count", 32'(rd_n), 32'd4);
    chk("postrst_refill_addr", last_rd, 32'h0000_6400);
    chk("postrst_load_data", cpu_data_o, 32'hA000_6404);
    release_req();

    repeat (2) @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
